alu_mem_unit: RTL and testbench

ALU_MEM_UNIT -- requirements
Module: alu_mem_unit

---
 rtl/alu_mem_unit_pkg.sv | 28 ++
 rtl/alu_mem_unit_if.sv | 32 +++
 rtl/alu_core.sv | 50 +++++
 rtl/alu_ctrl_dec.sv | 45 ++++
 rtl/data_mem.sv | 36 +++
 rtl/alu_mem_unit.sv | 51 +++++
 tb/tb_alu_mem_unit.sv | 274 +++++++++++++++++++++++++++
 7 files changed

// File: rtl/alu_mem_unit_pkg.sv
// Shared constants for the ALU/memory slice: ALU control codes, ALUOp classes, opcodes.
package alu_mem_unit_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_XOR = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [3:0] OPC_R_ARITH = 4'b0000;
  localparam logic [3:0] OPC_R_LOGIC = 4'b0001;
  localparam logic [3:0] OPC_ADDI    = 4'b0100;
  localparam logic [3:0] OPC_SLTI    = 4'b0101;
  localparam logic [3:0] OPC_ANDI    = 4'b0110;
  localparam logic [3:0] OPC_ORI     = 4'b0111;

endpackage

// File: rtl/alu_mem_unit_if.sv
// Operand, control and memory bus between the datapath and the ALU/memory unit.
interface alu_mem_unit_if;
  import alu_mem_unit_pkg::*;

  logic [1:0]        ALUOp;
  logic [3:0]        Opcode;
  logic [1:0]        Funct;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              CIN;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] WriteData;
  logic              MemWrite;
  logic              MemRead;
  logic [CTRL_W-1:0] ALUCtrl;
  logic [DATA_W-1:0] Result;
  logic              Zero;
  logic              Overflow;
  logic              CarryOut;
  logic [DATA_W-1:0] ReadData;

  modport master (
    output ALUOp, Opcode, Funct, A, B, CIN, MemAddr, WriteData, MemWrite, MemRead,
    input  ALUCtrl, Result, Zero, Overflow, CarryOut, ReadData
  );

  modport slave (
    input  ALUOp, Opcode, Funct, A, B, CIN, MemAddr, WriteData, MemWrite, MemRead,
    output ALUCtrl, Result, Zero, Overflow, CarryOut, ReadData
  );

endinterface

// File: rtl/alu_core.sv
// Combinational 16-bit ALU with zero, signed-overflow and carry/no-borrow flags.
module alu_core
  import alu_mem_unit_pkg::*;
(
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow,
  output logic              carry_out
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            lt;

  // Subtraction is A + ~B + 1, so bit 16 reads as "no borrow".
  assign sum  = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(cin);
  assign diff = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1'b1);
  assign lt   = $signed(a) < $signed(b);

  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    unique case (alu_ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = DATA_W'(lt);
      ALU_ADD: begin
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
        overflow  = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result    = diff[DATA_W-1:0];
        carry_out = diff[DATA_W];
        overflow  = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps ALUOp class, opcode and function field to an ALU operation.
module alu_ctrl_dec
  import alu_mem_unit_pkg::*;
(
  input  logic [1:0]        alu_op,
  input  logic [3:0]        opcode,
  input  logic [1:0]        funct,
  output logic [CTRL_W-1:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      ALUOP_MEM:    alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        if (opcode == OPC_R_ARITH) begin
          unique case (funct)
            2'b00:   alu_ctrl = ALU_ADD;
            2'b01:   alu_ctrl = ALU_SUB;
            2'b10:   alu_ctrl = ALU_SLT;
            default: alu_ctrl = ALU_ADD;
          endcase
        end else if (opcode == OPC_R_LOGIC) begin
          unique case (funct)
            2'b00:   alu_ctrl = ALU_AND;
            2'b01:   alu_ctrl = ALU_OR;
            2'b10:   alu_ctrl = ALU_XOR;
            default: alu_ctrl = ALU_NOR;
          endcase
        end
      end
      default: begin
        unique case (opcode)
          OPC_ADDI: alu_ctrl = ALU_ADD;
          OPC_SLTI: alu_ctrl = ALU_SLT;
          OPC_ANDI: alu_ctrl = ALU_AND;
          OPC_ORI:  alu_ctrl = ALU_OR;
          default:  alu_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed, word-organised data memory: synchronous write, combinational gated read.
module data_mem
  import alu_mem_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              unused_addr;

  // Byte lane bit and bits above the index are dropped, so addresses alias.
  assign idx         = addr[IDX_W:1];
  assign unused_addr = ^{addr[ADDR_W-1:IDX_W+1], addr[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = re ? mem[idx] : '0;

endmodule

// File: rtl/alu_mem_unit.sv
// ALU/memory unit top: control decoder feeding the ALU, plus the data memory.
module alu_mem_unit
  import alu_mem_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  alu_mem_unit_if.slave bus
);

  logic [CTRL_W-1:0] alu_ctrl;

  if (WIDTH != DATA_W) begin : g_bad_width
    $error("alu_mem_unit supports only a 16-bit datapath");
  end

  alu_ctrl_dec u_dec (
    .alu_op   (bus.ALUOp),
    .opcode   (bus.Opcode),
    .funct    (bus.Funct),
    .alu_ctrl (alu_ctrl)
  );

  assign bus.ALUCtrl = alu_ctrl;

  alu_core u_alu (
    .alu_ctrl  (alu_ctrl),
    .a         (bus.A),
    .b         (bus.B),
    .cin       (bus.CIN),
    .result    (bus.Result),
    .zero      (bus.Zero),
    .overflow  (bus.Overflow),
    .carry_out (bus.CarryOut)
  );

  data_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (Clock),
    .rst_n (Resetn),
    .addr  (bus.MemAddr),
    .wdata (bus.WriteData),
    .we    (bus.MemWrite),
    .re    (bus.MemRead),
    .rdata (bus.ReadData)
  );

endmodule

// File: tb/tb_alu_mem_unit.sv
// Self-checking bench for alu_mem_unit: directed literal cases plus randomized traffic vs a model.
module tb_alu_mem_unit;

  localparam int unsigned NWORDS = 128;

  logic Clock;
  logic Resetn;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_en = 1'b0;

  logic [15:0] model_mem [NWORDS];

  alu_mem_unit_if bus ();

  alu_mem_unit #(.DEPTH(NWORDS), .WIDTH(16)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder written as lookup tables.
  function automatic logic [3:0] m_ctrl(input logic [1:0] op, input logic [3:0] opc,
                                        input logic [1:0] f);
    logic [3:0] arith_tab [4];
    logic [3:0] logic_tab [4];
    arith_tab = '{4'b0010, 4'b0110, 4'b0111, 4'b0010};
    logic_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b1100};
    case (op)
      2'd0: return 4'b0010;
      2'd1: return 4'b0110;
      2'd2: begin
        if (opc == 4'd0) return arith_tab[f];
        if (opc == 4'd1) return logic_tab[f];
        return 4'b0010;
      end
      default: begin
        case (opc)
          4'd4:    return 4'b0010;
          4'd5:    return 4'b0111;
          4'd6:    return 4'b0000;
          4'd7:    return 4'b0001;
          default: return 4'b0010;
        endcase
      end
    endcase
  endfunction

  // Reference ALU using integer arithmetic and signed range checks.
  task automatic m_alu(input logic [3:0] ctrl, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, output logic [15:0] res, output logic ov,
                       output logic co);
    int ua, ub, sa, sb, t;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    res = 16'h0; ov = 1'b0; co = 1'b0;
    case (ctrl)
      4'b0010: begin
        t   = ua + ub + int'(cin);
        res = 16'(t);
        co  = (t > 65535);
        t   = sa + sb + int'(cin);
        ov  = (t > 32767) || (t < -32768);
      end
      4'b0110: begin
        res = 16'(ua - ub);
        co  = (ua >= ub);
        t   = sa - sb;
        ov  = (t > 32767) || (t < -32768);
      end
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0011: res = a ^ b;
      4'b1100: res = ~(a | b);
      4'b0111: res = (sa < sb) ? 16'h0001 : 16'h0000;
      default: res = 16'h0000;
    endcase
  endtask

  function automatic int widx(input logic [15:0] addr);
    return (int'(addr) % (2 * NWORDS)) / 2;
  endfunction

  // Model memory: cleared whenever reset is low, written on rising edges otherwise.
  initial for (int i = 0; i < NWORDS; i++) model_mem[i] = 16'h0;
  always @(negedge Resetn) for (int i = 0; i < NWORDS; i++) model_mem[i] = 16'h0;
  always @(posedge Clock) begin
    if (Resetn === 1'b1 && bus.MemWrite === 1'b1) model_mem[widx(bus.MemAddr)] = bus.WriteData;
  end

  // Single compare process on the falling edge, away from write edges.
  always @(negedge Clock) begin
    if (cmp_en) begin
      logic [3:0]  ec;
      logic [15:0] er, erd;
      logic        eo, eco;
      ec = m_ctrl(bus.ALUOp, bus.Opcode, bus.Funct);
      m_alu(ec, bus.A, bus.B, bus.CIN, er, eo, eco);
      erd = bus.MemRead ? model_mem[widx(bus.MemAddr)] : 16'h0;
      chk("m_ctrl", 16'(bus.ALUCtrl), 16'(ec));
      chk("m_result", bus.Result, er);
      chk("m_zero", 16'(bus.Zero), 16'(er == 16'h0));
      chk("m_ovf", 16'(bus.Overflow), 16'(eo));
      chk("m_carry", 16'(bus.CarryOut), 16'(eco));
      chk("m_rdata", bus.ReadData, erd);
    end
  end

  task automatic set_alu(input logic [1:0] op, input logic [3:0] opc, input logic [1:0] f,
                         input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus.ALUOp = op; bus.Opcode = opc; bus.Funct = f;
    bus.A = a; bus.B = b; bus.CIN = cin;
  endtask

  task automatic set_mem(input logic [15:0] addr, input logic [15:0] wd, input logic we,
                         input logic re);
    bus.MemAddr = addr; bus.WriteData = wd; bus.MemWrite = we; bus.MemRead = re;
  endtask

  task automatic next_slot();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] edges [5];
    edges = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0;
    set_alu(2'b00, 4'h0, 2'b00, 16'h0, 16'h0, 1'b0);
    set_mem(16'h0010, 16'h0, 1'b0, 1'b1);
    #1 cmp_en = 1'b1;

    // Reset held: reads are zero and writes are blocked.
    set_mem(16'h0010, 16'hAAAA, 1'b1, 1'b1);
    next_slot();
    @(negedge Clock);
    chk("rst_read", bus.ReadData, 16'h0000);
    next_slot();
    Resetn = 1'b1;
    set_mem(16'h0010, 16'h0, 1'b0, 1'b1);
    @(negedge Clock);
    chk("post_rst_read", bus.ReadData, 16'h0000);

    next_slot();
    set_alu(2'b00, 4'h0, 2'b00, 16'h0005, 16'h0003, 1'b0);
    @(negedge Clock);
    chk("add_ctrl", 16'(bus.ALUCtrl), 16'h0002);
    chk("add_res", bus.Result, 16'h0008);
    chk("add_zero", 16'(bus.Zero), 16'h0);
    chk("add_co", 16'(bus.CarryOut), 16'h0);

    next_slot();
    set_alu(2'b01, 4'h0, 2'b00, 16'h1234, 16'h1234, 1'b1);
    @(negedge Clock);
    chk("sub_ctrl", 16'(bus.ALUCtrl), 16'h0006);
    chk("sub_res", bus.Result, 16'h0000);
    chk("sub_zero", 16'(bus.Zero), 16'h1);
    chk("sub_co", 16'(bus.CarryOut), 16'h1);
    chk("sub_ovf", 16'(bus.Overflow), 16'h0);

    next_slot();
    set_alu(2'b00, 4'h0, 2'b00, 16'h7FFF, 16'h0001, 1'b0);
    @(negedge Clock);
    chk("ovf_res", bus.Result, 16'h8000);
    chk("ovf_ovf", 16'(bus.Overflow), 16'h1);
    chk("ovf_co", 16'(bus.CarryOut), 16'h0);

    next_slot();
    set_alu(2'b00, 4'h0, 2'b00, 16'hFFFF, 16'h0001, 1'b0);
    @(negedge Clock);
    chk("wrap_res", bus.Result, 16'h0000);
    chk("wrap_co", 16'(bus.CarryOut), 16'h1);
    chk("wrap_zero", 16'(bus.Zero), 16'h1);

    next_slot();
    set_alu(2'b10, 4'h0, 2'b10, 16'hFFFE, 16'h0001, 1'b0);
    @(negedge Clock);
    chk("slt_ctrl", 16'(bus.ALUCtrl), 16'h0007);
    chk("slt_res", bus.Result, 16'h0001);

    next_slot();
    set_alu(2'b10, 4'h1, 2'b11, 16'h0000, 16'h0000, 1'b0);
    @(negedge Clock);
    chk("nor_ctrl", 16'(bus.ALUCtrl), 16'h000C);
    chk("nor_res", bus.Result, 16'hFFFF);

    // Store then load through the odd byte address of the same word.
    next_slot();
    set_mem(16'h0010, 16'hBEEF, 1'b1, 1'b0);
    next_slot();
    set_mem(16'h0011, 16'h0, 1'b0, 1'b1);
    @(negedge Clock);
    chk("ld_odd", bus.ReadData, 16'hBEEF);
    next_slot();
    set_mem(16'h0011, 16'h0, 1'b0, 1'b0);
    @(negedge Clock);
    chk("ld_gated", bus.ReadData, 16'h0000);
    next_slot();
    set_mem(16'h0110, 16'h0, 1'b0, 1'b1);
    @(negedge Clock);
    chk("ld_alias", bus.ReadData, 16'hBEEF);

    // Same-word read and write: old value before the edge, new after.
    next_slot();
    set_mem(16'h0020, 16'h5555, 1'b1, 1'b0);
    next_slot();
    set_mem(16'h0020, 16'h1234, 1'b1, 1'b1);
    @(negedge Clock);
    chk("rw_old", bus.ReadData, 16'h5555);
    next_slot();
    set_mem(16'h0020, 16'h0, 1'b0, 1'b1);
    @(negedge Clock);
    chk("rw_new", bus.ReadData, 16'h1234);

    // Mid-cycle reset pulse wipes the stored word.
    next_slot();
    set_mem(16'h0010, 16'h0, 1'b0, 1'b1);
    Resetn = 1'b0;
    #2 Resetn = 1'b1;
    @(negedge Clock);
    chk("rst_pulse", bus.ReadData, 16'h0000);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 2000; n++) begin
      int r;
      next_slot();
      if (Resetn == 1'b0) Resetn = 1'b1;
      set_alu(2'($urandom), 4'($urandom_range(0, 9)), 2'($urandom),
              pick_operand(), pick_operand(), 1'($urandom));
      set_mem(16'($urandom), 16'($urandom), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 1) == 0));
      r = int'($urandom_range(0, 299));
      if (r == 0) begin
        Resetn = 1'b0;
        #1 Resetn = 1'b1;
      end else if (r == 1) begin
        Resetn = 1'b0;
      end
    end

    next_slot();
    Resetn = 1'b1;
    @(negedge Clock);
    #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
